wb_stage_pipe: RTL and testbench
================================

Name: wb_stage_pipe

Overview:
- Parametrised writeback stage for the RV32 pipeline core. Successor to the fixed 32-bit, 3-source writeback stage.
- Takes the memory-stage bundle through a valid/ready handshake.
- Extracts and sign/zero-extends load data, selects the result from 4 sources, and registers the result, rd and write-enable toward the register file.
- Adds stall/flush control, x0 write suppression and a retired-instruction counter.

Parameters:
- XLEN, 32, datapath width; 32 or 64.
- REG_ADDR_W, 5, register-index width.
- CNT_W, 64, retired-instruction counter width.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-low reset.
- in_valid  in  1  memory-stage bundle valid.
- in_ready  out  1  stage can accept a bundle.
- flush  in  1  discard the held bundle and the incoming bundle.
- reg_write_in  in  1  instruction writes rd.
- result_src  in  2  0=ALU, 1=load, 2=PC+4, 3=immediate/CSR.
- funct3  in  3  load type: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU, 011 LD (XLEN=64 only), 110 LWU (XLEN=64 only).
- alu_result  in  XLEN  ALU result; low bits are the load byte offset.
- read_data  in  XLEN  raw memory word.
- pc_plus4  in  XLEN  PC+4.
- imm_csr  in  XLEN  immediate/CSR value.
- rd_in  in  REG_ADDR_W  destination register.
- out_valid  out  1  registered bundle valid.
- out_ready  in  1  register-file port accepts.
- reg_write_out  out  1  registered write enable, already qualified.
- rd_out  out  REG_ADDR_W  registered destination register.
- result_out  out  XLEN  registered result.
- fwd_result  out  XLEN  combinational selected result, for hazard forwarding.
- instret  out  CNT_W  retired-instruction count.

Behaviour:
- Reset (rst=0, asynchronous): out_valid=0, reg_write_out=0, rd_out=0, result_out=0, instret=0. in_ready is 1 from the first cycle after reset.
- Handshake:
  - in_ready = !out_valid | out_ready.
  - A bundle is accepted when in_valid & in_ready.
  - One-cycle latency: an accepted bundle appears on the outputs at the next clk edge.
- Retire:
  - out_valid & out_ready retires the held bundle.
  - If no new bundle is accepted in the same cycle, out_valid drops to 0.
  - Accept and retire in the same cycle: the new bundle replaces the old, with no bubble.
- Stall: while out_valid=1 and out_ready=0, all registered outputs hold stable and in_ready=0.
- Flush:
  - On the next edge, out_valid=0 and reg_write_out=0. The incoming bundle is dropped.
  - instret does not count the dropped bundles.
  - Flush takes priority over accept and retire.
- Load extraction, using the offset in alu_result low bits (2 bits for XLEN=32, 3 bits for XLEN=64):
  - The byte or halfword lane is selected from read_data, then sign- or zero-extended to XLEN.
  - Misaligned halfword/word offsets take the lane at the offset truncated to natural alignment (no trap).
  - An unsupported funct3 yields 0.
- Result selection: fwd_result is a pure combinational function of the current inputs; result_out registers it on accept.
- x0 suppression: reg_write_out = reg_write_in & (rd_in != 0), captured on accept. result_out is still captured.
- instret:
  - Increments by 1 on each retire with out_valid & out_ready & !flush.
  - Wraps modulo 2^CNT_W.
- Reset mid-operation: the held bundle is lost immediately; reg_write_out falls asynchronously.
- All register updates use nonblocking assignment, inside a single clocked process per register group.

Decomposition:
- Shared package wb_pkg:
  - result_src encodings RES_ALU, RES_LOAD, RES_PC4, RES_IMM.
  - funct3 load encodings F3_LB through F3_LWU.
- One sub-module, load_align: combinational lane select plus extension, parametrised on XLEN.
- The 4:1 result mux is inline. It generalises the existing 3:1 mux.

Test Plan:
- Reset, then a single accept: result_src=0, alu_result=0x1234, rd_in=5, reg_write_in=1 -> after one edge, out_valid=1, result_out=0x00001234, rd_out=5, reg_write_out=1; then out_ready=1 -> instret=1.
- Loads with read_data=0x80FF7F01, result_src=1:
  - LB, offset 3 -> 0xFFFFFF80.
  - LBU, offset 3 -> 0x00000080.
  - LH, offset 2 -> 0xFFFF80FF.
  - LHU, offset 0 -> 0x00007F01.
  - LW -> 0x80FF7F01.
- Back-pressure: out_ready=0 for 3 cycles with in_valid=1 -> in_ready=0, outputs unchanged, instret unchanged; then out_ready=1 -> the next bundle lands with no bubble.
- x0 write: rd_in=0, reg_write_in=1, alu_result=0xDEAD -> reg_write_out=0, result_out=0xDEAD, instret still increments on retire.
- Flush while stalled: out_valid=1, out_ready=0, flush=1 -> next edge out_valid=0, reg_write_out=0, instret unchanged.
- Asynchronous reset asserted mid-stall -> all outputs go to 0 immediately, without waiting for a clk edge. Counter wrap: CNT_W=4, 17 retires -> instret=1.

Source files
------------

// File: rtl/wb_pkg.sv
// Shared encodings for the writeback stage: result-source select and load funct3 types.
package wb_pkg;

    typedef enum logic [1:0] {
        RES_ALU  = 2'd0,
        RES_LOAD = 2'd1,
        RES_PC4  = 2'd2,
        RES_IMM  = 2'd3
    } res_src_e;

    typedef enum logic [2:0] {
        F3_LB  = 3'b000,
        F3_LH  = 3'b001,
        F3_LW  = 3'b010,
        F3_LD  = 3'b011,
        F3_LBU = 3'b100,
        F3_LHU = 3'b101,
        F3_LWU = 3'b110
    } load_f3_e;

    // Byte-offset width inside one XLEN word: 2 bits for RV32, 3 bits for RV64.
    function automatic int off_width(input int xlen);
        return (xlen == 64) ? 3 : 2;
    endfunction

endpackage

// File: rtl/load_align.sv
// Load lane extraction: picks the byte/half/word lane at the address offset and extends it to XLEN.
module load_align
    import wb_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int OFF_W = off_width(XLEN)
) (
    input  logic [2:0]       funct3_i,
    input  logic [OFF_W-1:0] offset_i,
    input  logic [XLEN-1:0]  read_data_i,
    output logic [XLEN-1:0]  load_o
);

    localparam logic [OFF_W-1:0] HALF_MASK = ~(OFF_W'(1));
    localparam logic [OFF_W-1:0] WORD_MASK = ~(OFF_W'(3));

    // Misaligned halfword/word offsets are truncated down to natural alignment.
    logic [OFF_W-1:0] half_off_s;
    logic [OFF_W-1:0] word_off_s;
    logic [7:0]       byte_s;
    logic [15:0]      half_s;
    logic [31:0]      word_s;

    assign half_off_s = offset_i & HALF_MASK;
    assign word_off_s = offset_i & WORD_MASK;
    assign byte_s     = read_data_i[{offset_i,   3'b000} +: 8];
    assign half_s     = read_data_i[{half_off_s, 3'b000} +: 16];
    assign word_s     = read_data_i[{word_off_s, 3'b000} +: 32];

    // Extension per load type; 64-bit-only encodings return zero on RV32.
    always_comb begin
        load_o = {XLEN{1'b0}};
        case (funct3_i)
            F3_LB:   load_o = XLEN'($signed(byte_s));
            F3_LH:   load_o = XLEN'($signed(half_s));
            F3_LW:   load_o = XLEN'($signed(word_s));
            F3_LBU:  load_o = XLEN'(byte_s);
            F3_LHU:  load_o = XLEN'(half_s);
            F3_LD: begin
                if (XLEN == 64) begin
                    load_o = read_data_i;
                end else begin
                    load_o = {XLEN{1'b0}};
                end
            end
            F3_LWU: begin
                if (XLEN == 64) begin
                    load_o = XLEN'(word_s);
                end else begin
                    load_o = {XLEN{1'b0}};
                end
            end
            default: load_o = {XLEN{1'b0}};
        endcase
    end

endmodule

// File: rtl/wb_stage_pipe.sv
// Writeback stage: valid/ready skid-free register toward the register file with
// result selection, x0 write suppression, flush and a retired-instruction counter.
module wb_stage_pipe
    import wb_pkg::*;
#(
    parameter int XLEN       = 32,
    parameter int REG_ADDR_W = 5,
    parameter int CNT_W      = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic                  flush,
    input  logic                  reg_write_in,
    input  logic [1:0]            result_src,
    input  logic [2:0]            funct3,
    input  logic [XLEN-1:0]       alu_result,
    input  logic [XLEN-1:0]       read_data,
    input  logic [XLEN-1:0]       pc_plus4,
    input  logic [XLEN-1:0]       imm_csr,
    input  logic [REG_ADDR_W-1:0] rd_in,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  reg_write_out,
    output logic [REG_ADDR_W-1:0] rd_out,
    output logic [XLEN-1:0]       result_out,
    output logic [XLEN-1:0]       fwd_result,
    output logic [CNT_W-1:0]      instret
);

    localparam int OFF_W = off_width(XLEN);

    logic                  valid_q, valid_d;
    logic                  wen_q, wen_d;
    logic [REG_ADDR_W-1:0] rd_q, rd_d;
    logic [XLEN-1:0]       res_q, res_d;
    logic [CNT_W-1:0]      instret_q, instret_d;
    logic [XLEN-1:0]       load_s;
    logic [XLEN-1:0]       fwd_s;
    logic                  in_ready_s;
    logic                  accept_s;
    logic                  retire_s;

    load_align #(
        .XLEN  (XLEN),
        .OFF_W (OFF_W)
    ) u_load_align (
        .funct3_i    (funct3),
        .offset_i    (alu_result[OFF_W-1:0]),
        .read_data_i (read_data),
        .load_o      (load_s)
    );

    // Result mux shared by the forwarding path and the output register.
    always_comb begin
        fwd_s = alu_result;
        case (result_src)
            RES_ALU:  fwd_s = alu_result;
            RES_LOAD: fwd_s = load_s;
            RES_PC4:  fwd_s = pc_plus4;
            RES_IMM:  fwd_s = imm_csr;
            default:  fwd_s = alu_result;
        endcase
    end

    assign in_ready_s = ~valid_q | out_ready;
    assign accept_s   = in_valid & in_ready_s & ~flush;
    assign retire_s   = valid_q & out_ready & ~flush;

    // Next-state: flush beats accept, accept beats a plain retire.
    always_comb begin
        valid_d   = valid_q;
        wen_d     = wen_q;
        rd_d      = rd_q;
        res_d     = res_q;
        instret_d = instret_q;
        if (flush) begin
            valid_d = 1'b0;
            wen_d   = 1'b0;
        end else if (accept_s) begin
            valid_d = 1'b1;
            wen_d   = reg_write_in & (rd_in != {REG_ADDR_W{1'b0}});
            rd_d    = rd_in;
            res_d   = fwd_s;
        end else if (retire_s) begin
            valid_d = 1'b0;
        end else begin
            valid_d = valid_q;
        end
        if (retire_s) begin
            instret_d = instret_q + CNT_W'(1);
        end else begin
            instret_d = instret_q;
        end
    end

    // Handshake control registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_q <= 1'b0;
            wen_q   <= 1'b0;
        end else begin
            valid_q <= valid_d;
            wen_q   <= wen_d;
        end
    end

    // Payload registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_q  <= {REG_ADDR_W{1'b0}};
            res_q <= {XLEN{1'b0}};
        end else begin
            rd_q  <= rd_d;
            res_q <= res_d;
        end
    end

    // Retired-instruction counter, wraps naturally.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            instret_q <= {CNT_W{1'b0}};
        end else begin
            instret_q <= instret_d;
        end
    end

    assign in_ready      = in_ready_s;
    assign out_valid     = valid_q;
    assign reg_write_out = wen_q;
    assign rd_out        = rd_q;
    assign result_out    = res_q;
    assign fwd_result    = fwd_s;
    assign instret       = instret_q;

endmodule

// File: tb/tb_wb_stage_pipe.sv
// Scoreboard bench for wb_stage_pipe; a second instance with a 4-bit counter checks wrap.
module tb_wb_stage_pipe;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        in_valid = 1'b0;
    logic        flush = 1'b0;
    logic        reg_write_in = 1'b0;
    logic [1:0]  result_src = 2'd0;
    logic [2:0]  funct3 = 3'd0;
    logic [31:0] alu_result = 32'd0;
    logic [31:0] read_data = 32'd0;
    logic [31:0] pc_plus4 = 32'd0;
    logic [31:0] imm_csr = 32'd0;
    logic [4:0]  rd_in = 5'd0;
    logic        out_ready = 1'b0;

    logic        in_ready, out_valid, reg_write_out;
    logic [4:0]  rd_out;
    logic [31:0] result_out, fwd_result;
    logic [63:0] instret;

    logic        c_in_ready, c_out_valid, c_reg_write_out;
    logic [4:0]  c_rd_out;
    logic [31:0] c_result_out, c_fwd_result;
    logic [3:0]  c_instret;

    typedef struct {
        logic [31:0] res;
        logic [4:0]  rd;
        logic        wen;
    } exp_t;

    exp_t        sb[$];
    int          checks = 0;
    int          failures = 0;
    logic        m_valid = 1'b0;
    logic [63:0] m_instret = 64'd0;

    always #5 clk = ~clk;

    wb_stage_pipe #(.XLEN(32), .REG_ADDR_W(5), .CNT_W(64)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .flush(flush),
        .reg_write_in(reg_write_in), .result_src(result_src), .funct3(funct3),
        .alu_result(alu_result), .read_data(read_data), .pc_plus4(pc_plus4),
        .imm_csr(imm_csr), .rd_in(rd_in), .out_valid(out_valid), .out_ready(out_ready),
        .reg_write_out(reg_write_out), .rd_out(rd_out), .result_out(result_out),
        .fwd_result(fwd_result), .instret(instret)
    );

    wb_stage_pipe #(.XLEN(32), .REG_ADDR_W(5), .CNT_W(4)) u_cnt (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(c_in_ready), .flush(flush),
        .reg_write_in(reg_write_in), .result_src(result_src), .funct3(funct3),
        .alu_result(alu_result), .read_data(read_data), .pc_plus4(pc_plus4),
        .imm_csr(imm_csr), .rd_in(rd_in), .out_valid(c_out_valid), .out_ready(out_ready),
        .reg_write_out(c_reg_write_out), .rd_out(c_rd_out), .result_out(c_result_out),
        .fwd_result(c_fwd_result), .instret(c_instret)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    task automatic pop_compare(input string name);
        exp_t e;
        checks++;
        if (sb.size() == 0) begin
            failures++;
            $display("FAIL %s scoreboard empty actual_valid=%0b required=queued entry", name, out_valid);
        end else begin
            e = sb.pop_front();
            if (out_valid !== 1'b1 || result_out !== e.res || rd_out !== e.rd || reg_write_out !== e.wen) begin
                failures++;
                $display("FAIL %s actual v=%0b res=0x%0h rd=%0d we=%0b required v=1 res=0x%0h rd=%0d we=%0b",
                         name, out_valid, result_out, rd_out, reg_write_out, e.res, e.rd, e.wen);
            end
        end
    endtask

    task automatic drive(input logic [1:0] src, input logic [2:0] f3, input logic [31:0] alu,
                         input logic [31:0] rdata, input logic [4:0] rd, input logic wen);
        result_src   = src;
        funct3       = f3;
        alu_result   = alu;
        read_data    = rdata;
        rd_in        = rd;
        reg_write_in = wen;
        pc_plus4     = 32'h0000_1004;
        imm_csr      = 32'hCAFE_0000;
    endtask

    // One accepted bundle; the stage must be ready when this is called.
    task automatic send(input string name, input logic [1:0] src, input logic [2:0] f3,
                        input logic [31:0] alu, input logic [31:0] rdata, input logic [4:0] rd,
                        input logic wen, input logic [31:0] exp_res);
        exp_t e;
        @(negedge clk);
        drive(src, f3, alu, rdata, rd, wen);
        in_valid = 1'b1;
        #1;
        if (fwd_result !== exp_res) begin
            $display("FAIL %s_fwd actual=0x%0h required=0x%0h", name, fwd_result, exp_res);
            failures++;
        end
        checks++;
        e.res = exp_res;
        e.rd  = rd;
        e.wen = wen && (rd != 5'd0);
        sb.push_back(e);
        if (m_valid && out_ready) m_instret++;
        m_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        pop_compare(name);
    endtask

    task automatic idle_retire();
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        if (m_valid) m_instret++;
        m_valid = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
        chk("rst_reg_write", {63'd0, reg_write_out}, 64'd0);
        chk("rst_rd_out", {59'd0, rd_out}, 64'd0);
        chk("rst_result", {32'd0, result_out}, 64'd0);
        chk("rst_instret", instret, 64'd0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_in_ready", {63'd0, in_ready}, 64'd1);
        m_valid = 1'b0;
        m_instret = 64'd0;
    endtask

    task automatic test_single();
        out_ready = 1'b0;
        send("single_alu", 2'd0, 3'd0, 32'h0000_1234, 32'd0, 5'd5, 1'b1, 32'h0000_1234);
        idle_retire();
        chk("single_instret", instret, 64'd1);
        chk("single_drop_valid", {63'd0, out_valid}, 64'd0);
    endtask

    task automatic test_loads();
        out_ready = 1'b1;
        send("lb_off3",  2'd1, 3'b000, 32'h0000_0003, 32'h80FF_7F01, 5'd1, 1'b1, 32'hFFFF_FF80);
        send("lbu_off3", 2'd1, 3'b100, 32'h0000_0003, 32'h80FF_7F01, 5'd2, 1'b1, 32'h0000_0080);
        send("lh_off2",  2'd1, 3'b001, 32'h0000_0002, 32'h80FF_7F01, 5'd3, 1'b1, 32'hFFFF_80FF);
        send("lhu_off0", 2'd1, 3'b101, 32'h0000_0000, 32'h80FF_7F01, 5'd4, 1'b1, 32'h0000_7F01);
        send("lw",       2'd1, 3'b010, 32'h0000_0000, 32'h80FF_7F01, 5'd6, 1'b1, 32'h80FF_7F01);
        send("lb_off1",  2'd1, 3'b000, 32'h0000_0001, 32'h80FF_7F01, 5'd7, 1'b1, 32'h0000_007F);
        send("lh_mis3",  2'd1, 3'b001, 32'h0000_0003, 32'h80FF_7F01, 5'd8, 1'b1, 32'hFFFF_80FF);
        send("lw_mis1",  2'd1, 3'b010, 32'h0000_0001, 32'h80FF_7F01, 5'd9, 1'b1, 32'h80FF_7F01);
        send("ld_rv32",  2'd1, 3'b011, 32'h0000_0000, 32'h80FF_7F01, 5'd10, 1'b1, 32'h0000_0000);
        send("bad_f3",   2'd1, 3'b111, 32'h0000_0000, 32'h80FF_7F01, 5'd11, 1'b1, 32'h0000_0000);
        send("pc4_src",  2'd2, 3'b000, 32'h0000_0003, 32'h80FF_7F01, 5'd12, 1'b0, 32'h0000_1004);
        send("imm_src",  2'd3, 3'b000, 32'h0000_0003, 32'h80FF_7F01, 5'd13, 1'b1, 32'hCAFE_0000);
        idle_retire();
        chk("loads_instret", instret, m_instret);
    endtask

    task automatic test_back_to_back();
        logic [63:0] held_cnt;
        exp_t e;
        out_ready = 1'b0;
        send("bp_first", 2'd0, 3'd0, 32'h0000_AAAA, 32'd0, 5'd14, 1'b1, 32'h0000_AAAA);
        held_cnt = instret;
        @(negedge clk);
        drive(2'd0, 3'd0, 32'h0000_BBBB, 32'd0, 5'd15, 1'b1);
        in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("bp_in_ready_low", {63'd0, in_ready}, 64'd0);
            @(posedge clk);
            #1;
            if (out_valid !== 1'b1 || result_out !== 32'h0000_AAAA || rd_out !== 5'd14 ||
                reg_write_out !== 1'b1 || instret !== held_cnt) begin
                $display("FAIL bp_hold actual v=%0b res=0x%0h rd=%0d we=%0b cnt=%0d required v=1 res=0xaaaa rd=14 we=1 cnt=%0d",
                         out_valid, result_out, rd_out, reg_write_out, instret, held_cnt);
                failures++;
            end
            checks++;
            @(negedge clk);
        end
        out_ready = 1'b1;
        #1;
        chk("bp_in_ready_high", {63'd0, in_ready}, 64'd1);
        e.res = 32'h0000_BBBB;
        e.rd  = 5'd15;
        e.wen = 1'b1;
        sb.push_back(e);
        m_instret++;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        pop_compare("bp_no_bubble");
        chk("bp_instret", instret, m_instret);
        idle_retire();
    endtask

    task automatic test_x0();
        out_ready = 1'b0;
        send("x0_write", 2'd0, 3'd0, 32'h0000_DEAD, 32'd0, 5'd0, 1'b1, 32'h0000_DEAD);
        idle_retire();
        chk("x0_instret", instret, m_instret);
    endtask

    task automatic test_flush_stall();
        logic [63:0] held_cnt;
        out_ready = 1'b0;
        send("fl_held", 2'd0, 3'd0, 32'h0000_F00D, 32'd0, 5'd20, 1'b1, 32'h0000_F00D);
        held_cnt = instret;
        @(negedge clk);
        drive(2'd0, 3'd0, 32'h0000_BEEF, 32'd0, 5'd21, 1'b1);
        in_valid = 1'b1;
        flush    = 1'b1;
        @(posedge clk);
        #1;
        chk("fl_out_valid", {63'd0, out_valid}, 64'd0);
        chk("fl_reg_write", {63'd0, reg_write_out}, 64'd0);
        chk("fl_instret", instret, held_cnt);
        @(negedge clk);
        flush    = 1'b0;
        in_valid = 1'b0;
        m_valid  = 1'b0;
        idle_retire();
        chk("fl_after_instret", instret, held_cnt);
        chk("fl_after_valid", {63'd0, out_valid}, 64'd0);
    endtask

    task automatic test_async_reset();
        out_ready = 1'b0;
        send("ar_held", 2'd3, 3'd0, 32'd0, 32'd0, 5'd22, 1'b1, 32'hCAFE_0000);
        @(negedge clk);
        #2;
        rst = 1'b0;
        #1;
        if (out_valid !== 1'b0 || reg_write_out !== 1'b0 || rd_out !== 5'd0 ||
            result_out !== 32'd0 || instret !== 64'd0) begin
            $display("FAIL async_reset actual v=%0b we=%0b rd=%0d res=0x%0h cnt=%0d required all zero",
                     out_valid, reg_write_out, rd_out, result_out, instret);
            failures++;
        end
        checks++;
        @(negedge clk);
        rst = 1'b1;
        m_valid = 1'b0;
        m_instret = 64'd0;
    endtask

    task automatic test_wrap();
        out_ready = 1'b1;
        for (int i = 0; i < 17; i++) begin
            send("wrap_bundle", 2'd0, 3'd0, 32'(i), 32'd0, 5'(i + 1), 1'b1, 32'(i));
        end
        idle_retire();
        chk("wrap_c_instret", {60'd0, c_instret}, 64'd1);
        chk("wrap_instret", instret, 64'd17);
        chk("wrap_model", instret, m_instret);
    endtask

    initial begin
        test_reset();
        test_single();
        test_loads();
        test_back_to_back();
        test_x0();
        test_flush_stall();
        test_async_reset();
        test_wrap();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
